// File: rtl/pwm_pkg.sv
// Shared mode encodings for the multi-channel dead-time PWM.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pwm_pkg;

   typedef enum logic [1:0] {
      COUNT_UP     = 2'd0,
      COUNT_DOWN   = 2'd1,
      COUNT_UPDOWN = 2'd2
   } _count_mode;

   typedef enum logic [1:0] {
      MASK_ZERO   = 2'd0,
      MASK_PERIOD = 2'd1,
      MASK_BOTH   = 2'd2
   } _mask_mode;

endpackage

// File: rtl/deadtime_gen.sv
// Dead-time insertion for one half-bridge: blanks both gates for deadtime cycles after every raw edge.
// Latency: gates follow raw one cycle later, plus deadtime blanking cycles after a change or enable rise.
// Backpressure: none; a raw change while blanking restarts the window, so short pulses are swallowed.
module deadtime_gen #(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                raw,
   input  logic [DT_WIDTH-1:0] deadtime,
   output logic                pwm_h,
   output logic                pwm_l
);

   localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic                raw_prev_q, raw_prev_d;
   logic                en_prev_q, en_prev_d;
   logic                pwm_h_q, pwm_h_d;
   logic                pwm_l_q, pwm_l_d;

   // Blanking counter and gate levels; gates only drive once the counter has drained.
   always_comb begin
      raw_prev_d = raw;
      en_prev_d  = enable;
      cnt_d      = cnt_q;
      pwm_h_d    = 1'b0;
      pwm_l_d    = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else begin
         // Enable rising is treated like a raw edge so the first drive also sees a dead band.
         if ((raw != raw_prev_q) || !en_prev_q) begin
            cnt_d = deadtime;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DT_ONE;
         end
         if (cnt_d == '0) begin
            pwm_h_d = raw;
            pwm_l_d = !raw;
         end
      end
   end

   // State registers with synchronous reset to the safe (both gates off) state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         raw_prev_q <= 1'b0;
         en_prev_q  <= 1'b0;
         pwm_h_q    <= 1'b0;
         pwm_l_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         raw_prev_q <= raw_prev_d;
         en_prev_q  <= en_prev_d;
         pwm_h_q    <= pwm_h_d;
         pwm_l_q    <= pwm_l_d;
      end
   end

   assign pwm_h = pwm_h_q;
   assign pwm_l = pwm_l_q;

endmodule

// File: rtl/pwm_multi_dt.sv
// Multi-channel PWM: one shared up/down/up-down carrier, N_CH compare channels, per-channel dead time.
// Latency: compare result registered one cycle after carrier; gates one further cycle plus dead time.
// Backpressure: none; free-running, shadowed settings reload only at mask_event while enabled.
module pwm_multi_dt
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int N_CH     = 3,
   parameter int DT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [WIDTH-1:0]      period,
   input  logic [WIDTH-1:0]      init_carr,
   input  logic [N_CH*WIDTH-1:0] compare,
   input  logic [DT_WIDTH-1:0]   deadtime,
   input  _count_mode            count_mode,
   input  _mask_mode             mask_mode,
   output logic [N_CH-1:0]       pwm_h,
   output logic [N_CH-1:0]       pwm_l,
   output logic [WIDTH-1:0]      carrier,
   output logic                  mask_event
);

   localparam logic [WIDTH-1:0] CARR_ONE = WIDTH'(1);

   logic [WIDTH-1:0]      period_q, period_d;
   logic [WIDTH-1:0]      init_carr_q, init_carr_d;
   logic [N_CH*WIDTH-1:0] compare_q, compare_d;
   logic [DT_WIDTH-1:0]   deadtime_q, deadtime_d;
   _count_mode            count_mode_q, count_mode_d;
   _mask_mode             mask_mode_q, mask_mode_d;
   logic [WIDTH-1:0]      carrier_q, carrier_d;
   logic                  dir_down_q, dir_down_d;
   logic [N_CH-1:0]       raw_q, raw_d;

   // Shadow-load strobe: carrier at zero and/or at period; a zero period loads every enabled cycle.
   always_comb begin
      mask_event = 1'b0;
      if (!reset && enable) begin
         mask_event = (period_q == '0)
                   || ((carrier_q == '0) && (mask_mode_q != MASK_PERIOD))
                   || ((carrier_q == period_q) && (mask_mode_q != MASK_ZERO));
      end
   end

   // Active settings track the inputs while stopped, and only at the mask point while running.
   always_comb begin
      period_d     = period_q;
      init_carr_d  = init_carr_q;
      compare_d    = compare_q;
      deadtime_d   = deadtime_q;
      count_mode_d = count_mode_q;
      mask_mode_d  = mask_mode_q;
      if (!enable || mask_event) begin
         period_d     = period;
         init_carr_d  = init_carr;
         compare_d    = compare;
         deadtime_d   = deadtime;
         count_mode_d = count_mode;
         mask_mode_d  = mask_mode;
      end
   end

   // Carrier sequencing; while stopped it parks at the start value clamped to the period.
   always_comb begin
      carrier_d  = carrier_q;
      dir_down_d = dir_down_q;
      if (!enable) begin
         carrier_d  = (init_carr_q < period_q) ? init_carr_q : period_q;
         dir_down_d = (count_mode_q == COUNT_DOWN);
      end else if (period_q == '0) begin
         carrier_d  = '0;
         dir_down_d = (count_mode_q == COUNT_DOWN);
      end else begin
         case (count_mode_q)
            COUNT_DOWN: begin
               dir_down_d = 1'b1;
               carrier_d  = ((carrier_q == '0) || (carrier_q > period_q)) ? period_q
                                                                          : carrier_q - CARR_ONE;
            end
            COUNT_UPDOWN: begin
               // Each extreme is visited for exactly one cycle before turning round.
               if (!dir_down_q) begin
                  if (carrier_q >= period_q) begin
                     carrier_d  = period_q - CARR_ONE;
                     dir_down_d = 1'b1;
                  end else begin
                     carrier_d = carrier_q + CARR_ONE;
                  end
               end else begin
                  if (carrier_q == '0) begin
                     carrier_d  = CARR_ONE;
                     dir_down_d = 1'b0;
                  end else begin
                     carrier_d = carrier_q - CARR_ONE;
                  end
               end
            end
            default: begin
               dir_down_d = 1'b0;
               carrier_d  = (carrier_q >= period_q) ? '0 : carrier_q + CARR_ONE;
            end
         endcase
      end
   end

   // Raw per-channel comparison against the shared carrier.
   always_comb begin
      raw_d = '0;
      for (int i = 0; i < N_CH; i++) begin
         raw_d[i] = (carrier_q < compare_q[i*WIDTH +: WIDTH]);
      end
   end

   // All carrier-side state; reset wins over enable and shadow loading.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_q     <= '0;
         init_carr_q  <= '0;
         compare_q    <= '0;
         deadtime_q   <= '0;
         count_mode_q <= COUNT_UP;
         mask_mode_q  <= MASK_ZERO;
         carrier_q    <= '0;
         dir_down_q   <= 1'b0;
         raw_q        <= '0;
      end else begin
         period_q     <= period_d;
         init_carr_q  <= init_carr_d;
         compare_q    <= compare_d;
         deadtime_q   <= deadtime_d;
         count_mode_q <= count_mode_d;
         mask_mode_q  <= mask_mode_d;
         carrier_q    <= carrier_d;
         dir_down_q   <= dir_down_d;
         raw_q        <= raw_d;
      end
   end

   assign carrier = carrier_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      deadtime_gen #(
         .DT_WIDTH (DT_WIDTH)
      ) u_deadtime_gen (
         .clk      (clk),
         .reset    (reset),
         .enable   (enable),
         .raw      (raw_q[i]),
         .deadtime (deadtime_q),
         .pwm_h    (pwm_h[i]),
         .pwm_l    (pwm_l[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Directed bench for pwm_multi_dt: carrier modes, shadowing, dead time, period-zero and enable/reset.
// Latency: expectations count edges from the cycle enable is raised.
// Backpressure: n/a; every wait is a fixed cycle count.
module tb_pwm_multi_dt;
   import pwm_pkg::*;

   localparam int WIDTH    = 16;
   localparam int N_CH     = 3;
   localparam int DT_WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  enable;
   logic [WIDTH-1:0]      period;
   logic [WIDTH-1:0]      init_carr;
   logic [N_CH*WIDTH-1:0] compare;
   logic [DT_WIDTH-1:0]   deadtime;
   _count_mode            count_mode;
   _mask_mode             mask_mode;
   logic [N_CH-1:0]       pwm_h;
   logic [N_CH-1:0]       pwm_l;
   logic [WIDTH-1:0]      carrier;
   logic                  mask_event;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_on   = 1'b0;

   // Expected carrier after edge j of a run (j=0 is the parked value) and expected raw compare.
   int cexp [0:63];
   bit rexp [0:N_CH-1][0:63];

   always #5 clk = ~clk;

   pwm_multi_dt #(
      .WIDTH    (WIDTH),
      .N_CH     (N_CH),
      .DT_WIDTH (DT_WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .period     (period),
      .init_carr  (init_carr),
      .compare    (compare),
      .deadtime   (deadtime),
      .count_mode (count_mode),
      .mask_mode  (mask_mode),
      .pwm_h      (pwm_h),
      .pwm_l      (pwm_l),
      .carrier    (carrier),
      .mask_event (mask_event)
   );

   // Gates of a channel must never be on together.
   always @(negedge clk) begin
      if (mon_on) begin
         n_checks++;
         if ((pwm_h & pwm_l) !== '0) begin
            n_fail++;
            $display("FAIL overlap at %0t: got h=%b l=%b required no common 1", $time, pwm_h, pwm_l);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int p, input int init, input int c0, input int c1, input int c2,
                            input int dt, input _count_mode cm, input _mask_mode mm);
      enable     = 1'b0;
      period     = p[WIDTH-1:0];
      init_carr  = init[WIDTH-1:0];
      compare    = {c2[WIDTH-1:0], c1[WIDTH-1:0], c0[WIDTH-1:0]};
      deadtime   = dt[DT_WIDTH-1:0];
      count_mode = cm;
      mask_mode  = mm;
      repeat (3) tick();
   endtask

   // Raw level seen by the gate stage after edge j: carrier one edge earlier against the compare.
   function automatic void fill_raw(input int ch, input int cmp_a, input int cmp_b, input int sw, input int nj);
      for (int j = 0; j <= nj; j++) begin
         int prev;
         prev = (j == 0) ? cexp[0] : cexp[j-1];
         rexp[ch][j] = (prev < ((j >= sw) ? cmp_b : cmp_a));
      end
   endfunction

   // A gate drives lvl only when raw has held lvl for the last dt+1 samples since enable.
   function automatic bit exp_lvl(input int ch, input int j, input int dt, input bit lvl);
      if (j - 1 - dt < 0) return 1'b0;
      for (int k = j - 1 - dt; k <= j - 1; k++) begin
         if (rexp[ch][k] != lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1;
      period = 16'd9; init_carr = 16'd5; compare = {16'd10, 16'd0, 16'd4};
      deadtime = 8'd2; count_mode = COUNT_UP; mask_mode = MASK_ZERO;
      tick(); tick();
      n_checks++;
      if (carrier !== 16'd0) begin n_fail++; $display("FAIL reset_carrier: got %0d required 0", carrier); end
      n_checks++;
      if (pwm_h !== 3'b000 || pwm_l !== 3'b000) begin
         n_fail++; $display("FAIL reset_gates: got h=%b l=%b required 000/000", pwm_h, pwm_l);
      end
      n_checks++;
      if (mask_event !== 1'b0) begin n_fail++; $display("FAIL reset_mask: got %b required 0", mask_event); end
      enable = 1'b0;
      reset  = 1'b0;
      mon_on = 1'b1;
      tick(); tick();
      n_checks++;
      if (carrier !== 16'd5) begin n_fail++; $display("FAIL park_init: got %0d required 5", carrier); end
      n_checks++;
      if (mask_event !== 1'b0) begin n_fail++; $display("FAIL park_mask: got %b required 0", mask_event); end
   endtask

   task automatic test_up_dt0();
      int hi;
      hi = 0;
      configure(9, 0, 4, 0, 10, 0, COUNT_UP, MASK_ZERO);
      for (int j = 0; j <= 30; j++) cexp[j] = j % 10;
      fill_raw(0, 4, 4, 99, 30); fill_raw(1, 0, 0, 99, 30); fill_raw(2, 10, 10, 99, 30);
      n_checks++;
      if (carrier !== 16'd0) begin n_fail++; $display("FAIL up_park: got %0d required 0", carrier); end
      enable = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         tick();
         n_checks++;
         if (carrier !== cexp[j][WIDTH-1:0]) begin
            n_fail++; $display("FAIL up_carrier j=%0d: got %0d required %0d", j, carrier, cexp[j]);
         end
         n_checks++;
         if (mask_event !== (cexp[j] == 0)) begin
            n_fail++; $display("FAIL up_mask j=%0d: got %b required %b", j, mask_event, cexp[j] == 0);
         end
         for (int c = 0; c < N_CH; c++) begin
            n_checks++;
            if (pwm_h[c] !== exp_lvl(c, j, 0, 1'b1) || pwm_l[c] !== exp_lvl(c, j, 0, 1'b0)) begin
               n_fail++;
               $display("FAIL up_gates ch%0d j=%0d: got h=%b l=%b required h=%b l=%b", c, j,
                        pwm_h[c], pwm_l[c], exp_lvl(c, j, 0, 1'b1), exp_lvl(c, j, 0, 1'b0));
            end
         end
         if (j >= 11 && j <= 20 && pwm_h[0] === 1'b1) hi++;
      end
      n_checks++;
      if (hi != 4) begin n_fail++; $display("FAIL up_duty: got %0d high cycles required 4", hi); end
   endtask

   task automatic test_updown_dt2();
      configure(8, 0, 4, 0, 9, 2, COUNT_UPDOWN, MASK_BOTH);
      for (int j = 0; j <= 40; j++) cexp[j] = ((j % 16) <= 8) ? (j % 16) : 16 - (j % 16);
      fill_raw(0, 4, 4, 99, 40); fill_raw(1, 0, 0, 99, 40); fill_raw(2, 9, 9, 99, 40);
      enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         tick();
         n_checks++;
         if (carrier !== cexp[j][WIDTH-1:0]) begin
            n_fail++; $display("FAIL ud_carrier j=%0d: got %0d required %0d", j, carrier, cexp[j]);
         end
         n_checks++;
         if (mask_event !== (cexp[j] == 0 || cexp[j] == 8)) begin
            n_fail++; $display("FAIL ud_mask j=%0d: got %b required %b", j, mask_event, cexp[j] == 0 || cexp[j] == 8);
         end
         for (int c = 0; c < N_CH; c++) begin
            n_checks++;
            if (pwm_h[c] !== exp_lvl(c, j, 2, 1'b1) || pwm_l[c] !== exp_lvl(c, j, 2, 1'b0)) begin
               n_fail++;
               $display("FAIL ud_gates ch%0d j=%0d: got h=%b l=%b required h=%b l=%b", c, j,
                        pwm_h[c], pwm_l[c], exp_lvl(c, j, 2, 1'b1), exp_lvl(c, j, 2, 1'b0));
            end
         end
      end
   endtask

   task automatic test_mask_zero();
      int hi_a;
      int hi_b;
      hi_a = 0; hi_b = 0;
      configure(9, 0, 4, 0, 10, 0, COUNT_UP, MASK_ZERO);
      for (int j = 0; j <= 30; j++) cexp[j] = j % 10;
      fill_raw(0, 4, 7, 12, 30);
      enable = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         tick();
         n_checks++;
         if (pwm_h[0] !== exp_lvl(0, j, 0, 1'b1) || pwm_l[0] !== exp_lvl(0, j, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL mask_gates j=%0d: got h=%b l=%b required h=%b l=%b", j,
                     pwm_h[0], pwm_l[0], exp_lvl(0, j, 0, 1'b1), exp_lvl(0, j, 0, 1'b0));
         end
         if (j >= 3 && j <= 12 && pwm_h[0] === 1'b1) hi_a++;
         if (j >= 13 && j <= 22 && pwm_h[0] === 1'b1) hi_b++;
         if (j == 5) begin
            n_checks++;
            if (carrier !== 16'd5) begin n_fail++; $display("FAIL mask_at5: got %0d required 5", carrier); end
            compare[WIDTH-1:0] = 16'd7;
         end
      end
      n_checks++;
      if (hi_a != 4) begin n_fail++; $display("FAIL mask_duty_old: got %0d required 4", hi_a); end
      n_checks++;
      if (hi_b != 7) begin n_fail++; $display("FAIL mask_duty_new: got %0d required 7", hi_b); end
   endtask

   task automatic test_pulse_swallow();
      int lo;
      lo = 0;
      configure(15, 0, 3, 0, 16, 5, COUNT_UP, MASK_ZERO);
      for (int j = 0; j <= 40; j++) cexp[j] = j % 16;
      fill_raw(0, 3, 3, 99, 40);
      enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         tick();
         n_checks++;
         if (pwm_h[0] !== 1'b0) begin n_fail++; $display("FAIL swallow_h j=%0d: got %b required 0", j, pwm_h[0]); end
         n_checks++;
         if (pwm_l[0] !== exp_lvl(0, j, 5, 1'b0)) begin
            n_fail++; $display("FAIL swallow_l j=%0d: got %b required %b", j, pwm_l[0], exp_lvl(0, j, 5, 1'b0));
         end
         if (j >= 17 && j <= 32 && pwm_l[0] === 1'b0) lo++;
      end
      n_checks++;
      if (lo != 8) begin n_fail++; $display("FAIL swallow_gap: got %0d low cycles required 8", lo); end
   endtask

   task automatic test_period_zero();
      configure(0, 7, 0, 1, 0, 3, COUNT_UP, MASK_PERIOD);
      for (int j = 0; j <= 12; j++) cexp[j] = 0;
      fill_raw(0, 0, 0, 99, 12); fill_raw(1, 1, 1, 99, 12); fill_raw(2, 0, 0, 99, 12);
      enable = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         n_checks++;
         if (carrier !== 16'd0 || mask_event !== 1'b1) begin
            n_fail++; $display("FAIL p0_carrier j=%0d: got carrier=%0d mask=%b required 0/1", j, carrier, mask_event);
         end
         for (int c = 0; c < N_CH; c++) begin
            n_checks++;
            if (pwm_h[c] !== exp_lvl(c, j, 3, 1'b1) || pwm_l[c] !== exp_lvl(c, j, 3, 1'b0)) begin
               n_fail++;
               $display("FAIL p0_gates ch%0d j=%0d: got h=%b l=%b required h=%b l=%b", c, j,
                        pwm_h[c], pwm_l[c], exp_lvl(c, j, 3, 1'b1), exp_lvl(c, j, 3, 1'b0));
            end
         end
      end
   endtask

   task automatic test_enable_reset_drop();
      configure(9, 0, 4, 0, 10, 0, COUNT_UP, MASK_ZERO);
      enable = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (pwm_h[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_h: got %b required 1", pwm_h[0]); end
      reset = 1'b1;
      tick();
      n_checks++;
      if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || carrier !== 16'd0 || mask_event !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: got h=%b l=%b carrier=%0d mask=%b required 000/000/0/0",
                  pwm_h, pwm_l, carrier, mask_event);
      end
      reset  = 1'b0;
      enable = 1'b0;
      configure(9, 0, 4, 0, 10, 0, COUNT_UP, MASK_ZERO);
      enable = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (pwm_h[0] !== 1'b1) begin n_fail++; $display("FAIL drop_pre_h: got %b required 1", pwm_h[0]); end
      enable = 1'b0;
      tick();
      n_checks++;
      if (pwm_h !== 3'b000 || pwm_l !== 3'b000 || mask_event !== 1'b0) begin
         n_fail++; $display("FAIL drop_gates: got h=%b l=%b mask=%b required 000/000/0", pwm_h, pwm_l, mask_event);
      end
      period = 16'd10; init_carr = 16'd12; count_mode = COUNT_DOWN;
      tick(); tick();
      n_checks++;
      if (carrier !== 16'd10) begin n_fail++; $display("FAIL reen_park: got %0d required 10", carrier); end
      enable = 1'b1;
      tick();
      n_checks++;
      if (carrier !== 16'd9) begin n_fail++; $display("FAIL reen_step1: got %0d required 9", carrier); end
      tick();
      n_checks++;
      if (carrier !== 16'd8) begin n_fail++; $display("FAIL reen_step2: got %0d required 8", carrier); end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_dt0();
      test_updown_dt2();
      test_mask_zero();
      test_pulse_swallow();
      test_period_zero();
      test_enable_reset_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_multi_dt.md
PWM_MULTI_DT -- requirements
Module: pwm_multi_dt

Interface
REQ-001 SHALL have parameter WIDTH, default 16, carrier/period/compare width in bits.
REQ-002 SHALL have parameter N_CH, default 3, number of compare channels sharing one carrier.
REQ-003 SHALL have parameter DT_WIDTH, default 8, dead-time counter width in bits.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run (1) / hold-safe (0).
REQ-007 SHALL have port period  input  WIDTH  carrier period (shadowed).
REQ-008 SHALL have port init_carr  input  WIDTH  carrier start value (shadowed).
REQ-009 SHALL have port compare  input  N_CH*WIDTH  per-channel compare, channel i at bits [i*WIDTH +: WIDTH] (shadowed).
REQ-010 SHALL have port deadtime  input  DT_WIDTH  dead time in clk cycles (shadowed).
REQ-011 SHALL have port count_mode  input  _count_mode  COUNT_UP / COUNT_DOWN / COUNT_UPDOWN (shadowed).
REQ-012 SHALL have port mask_mode  input  _mask_mode  shadow-update point: MASK_ZERO / MASK_PERIOD / MASK_BOTH (shadowed).
REQ-013 SHALL have port pwm_h  output  N_CH  high-side gate per channel.
REQ-014 SHALL have port pwm_l  output  N_CH  low-side gate per channel.
REQ-015 SHALL have port carrier  output  WIDTH  current carrier value.
REQ-016 SHALL have port mask_event  output  1  one-cycle pulse when shadows load.

Function
REQ-017 Active registers (period, init_carr, compare, deadtime, count_mode, mask_mode) SHALL load from inputs every cycle while enable=0, and only on cycles with mask_event=1 while enable=1; loaded values take effect the following cycle.
REQ-018 While enable=0: carrier SHALL equal min(init_carr_active, period_active), direction = up (down for COUNT_DOWN), pwm_h=pwm_l=0, mask_event=0.
REQ-019 COUNT_UP: carrier 0,1..period,0..; COUNT_DOWN: period..0,period..; COUNT_UPDOWN: 0..period..0, direction reverses at period and at 0 (each extreme held one cycle only).
REQ-020 period_active=0 SHALL hold carrier at 0 and assert mask_event every enabled cycle.
REQ-021 mask_event SHALL be combinational from registered state: 1 when enable=1 and (carrier==0 and mask_mode in {MASK_ZERO,MASK_BOTH}) or (carrier==period_active and mask_mode in {MASK_PERIOD,MASK_BOTH}).
REQ-022 Raw compare per channel SHALL be registered: raw_q[i] <= (carrier < compare_active[i]) (unsigned); compare=0 gives constant 0, compare>period gives constant 1.
REQ-023 Dead-time per channel: on raw_q change, both outputs SHALL go 0 on the next edge and a counter loads deadtime_active; when counter reaches 0, pwm_h=raw_q and pwm_l=~raw_q.
REQ-024 deadtime_active=0 SHALL give pwm_h=raw_q, pwm_l=~raw_q with one-cycle latency from raw_q and no gap.
REQ-025 A raw_q toggle while counting SHALL reload the counter; both outputs stay 0 (pulses shorter than deadtime are swallowed).
REQ-026 pwm_h[i] and pwm_l[i] SHALL never both be 1 in any cycle, including enable and reset transitions.
REQ-027 enable falling SHALL force pwm_h=pwm_l=0 on the next edge and clear dead-time counters; enable rising SHALL start counting from the held carrier value, first transition observed through the normal dead-time path.

Reset
REQ-028 On reset=1 at a clock edge: carrier=0, direction=up, all active registers=0, raw_q=0, dead-time counters=0, pwm_h=0, pwm_l=0; mask_event=0 while reset asserted.
REQ-029 Reset mid-period SHALL take priority over enable and mask_event in the same cycle.

Structure
REQ-030 _count_mode and _mask_mode enums SHALL reside in pwm_pkg; no new package constants.
REQ-031 Per-channel dead-time logic SHALL be sub-module deadtime_gen (DT_WIDTH param; ports clk, reset, enable, raw, deadtime, pwm_h, pwm_l), instantiated N_CH times by generate loop.

Verification
REQ-032 UP, period=9, compare ch0=4, deadtime=0 -> carrier 0..9 repeating, pwm_h high 4 of 10 cycles, pwm_l complementary, no gap.
REQ-033 UPDOWN, period=8, compare=4, deadtime=2 -> 16-cycle period; each edge: both low 2 cycles, then new level; pwm_h&pwm_l never 1.
REQ-034 MASK_ZERO, UP, period=9; change compare 4->7 at carrier=5 -> duty changes only from the period following carrier=0.
REQ-035 deadtime=5, compare giving 3-cycle high pulse -> pwm_h never rises, pwm_l low across pulse plus 5 cycles.
REQ-036 period=0 and compare=0 / compare=period+1 -> carrier stuck 0, mask_event every cycle; pwm_h constant 0 / constant 1 after dead time.
REQ-037 Assert reset and separately drop enable mid-period with pwm_h=1 -> both outputs 0 next edge; init_carr=12, period=10 on re-enable -> carrier starts at 10.
